dot_matrix_frame_capture: RTL and testbench
===========================================

// Module: dot_matrix_frame_capture
// PURPOSE
//  Receiving end of the RGB dot-matrix serial link: samples DS/SH_CP/ST_CP/MR/CAT
//  exactly as the dot-matrix driver emits them (74HC595-style chain + row select).
//  Deserialises each row, assembles a full 8x8 red/blue frame and presents it as
//  64-bit vectors with a valid strobe. Used as a loop-back checker and frame monitor.
// PARAMETERS
//  SYNC_STAGES  2   flops per input synchroniser; all five inputs use the same depth
//  ROW_BITS     16  bits shifted per row: 8 red then 8 blue
// PORTS
//  CLK         in   1   system clock
//  res         in   1   asynchronous reset, active-low
//  sh_cp       in   1   shift clock from driver; a rising edge shifts in ds
//  st_cp       in   1   storage clock; a rising edge latches the row
//  ds          in   1   serial data, MSB-first
//  mr_n        in   1   shift-register clear, active-low
//  cat         in   8   row select, one-hot active-high; bit r selects row r
//  red_frame   out  64  red pixels; bit [r*8+c] = row r, column c
//  blue_frame  out  64  blue pixels, same indexing
//  frame_valid out  1   1-cycle pulse when red_frame/blue_frame update
//  count_err   out  1   1-cycle pulse: latch seen after a shift count other than ROW_BITS
//  row_err     out  1   1-cycle pulse: latch seen with cat not one-hot
// BEHAVIOUR
//  - Reset (res=0, async): all outputs 0; sync flops, shift reg, bit counter,
//    row buffers and row mask cleared.
//  - Synchronise sh_cp, st_cp, ds, mr_n and cat through SYNC_STAGES flops. Detect
//    rising edges on the synchronised sh_cp/st_cp by comparing with a registered copy.
//  - Shift: on sh_cp rise, sr <= {sr[ROW_BITS-2:0], ds_s}. Bit counter increments
//    and saturates at 31.
//  - Clear: while mr_n_s=0, sr and the bit counter are held at 0. Shift edges are
//    ignored. The storage latch still works and captures 0.
//  - Latch: on st_cp rise, the row value is the sr content before any same-cycle
//    shift. Red columns 7..0 = sr[15:8]; blue columns 7..0 = sr[7:0].
//  - Row write, on the same latch cycle:
//    - if cat_s is one-hot, write row r of red_buf/blue_buf and set mask[r];
//    - otherwise, no write and pulse row_err the next cycle.
//  - Bit count check: if the counter is not ROW_BITS at latch, pulse count_err the
//    next cycle. The row is still written. The counter then restarts at 0.
//  - Simultaneous shift+latch edges in one cycle: latch takes the pre-shift sr, the
//    shift happens, and the counter restarts at 1.
//  - Frame complete: when a row write makes mask==8'hFF, on the next cycle:
//    - red_frame <= red_buf and blue_frame <= blue_buf, including the new row;
//    - frame_valid pulses and mask clears.
//    Rows may arrive in any order. A repeated row before completion overwrites its
//    buffer entry and does not advance completion.
//  - Latency: a pin-level st_cp rise writes the row buffer SYNC_STAGES+1 CLK later.
//    frame_valid follows 1 CLK after that.
//  - Between frame_valid pulses, red_frame/blue_frame hold their values.
//  - Input constraint: each input level must be held at least SYNC_STAGES+1 CLK;
//    ds must be stable from SYNC_STAGES CLK before to 1 CLK after each sh_cp rise.
//  - Reset mid-row or mid-frame discards partial data; no error pulse is produced.
// TESTING
//  1. 16 shifts of 16'hA55A, then latch, with cat=8'h01 for rows 0..7 = same data
//     -> one frame_valid; red_frame=64'hA5A5A5A5A5A5A5A5, blue_frame=64'h5A5A5A5A5A5A5A5A.
//  2. Rows sent in order 7..0, row r data = {r,r} bytes -> red/blue byte r == r;
//     frame_valid exactly once, 1 CLK after the row-0 write.
//  3. 15 shifts then latch -> count_err pulse; row written with the shifted value;
//     the next 16-shift row gives no error.
//  4. Latch with cat=8'h03, then with cat=8'h00 -> two row_err pulses; mask unchanged;
//     no frame_valid.
//  5. mr_n=0 mid-row, then latch -> row written as 0; shifts ignored while mr_n=0.
//  6. Same-cycle sh_cp+st_cp rises after 16 good shifts -> latched row = pre-shift
//     data; next latch after 15 more shifts gives no count_err.
//  7. Assert res mid-frame after 4 rows -> outputs 0 immediately; 8 fresh rows are
//     needed for the next frame_valid.

Source files
------------

// File: rtl/dot_matrix_frame_capture.sv
// Receiver for the RGB dot-matrix serial link: synchronises the 595-style pins,
// deserialises each row and publishes complete 8x8 red/blue frames.
module dot_matrix_frame_capture #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ROW_BITS    = 16
) (
    input  logic        CLK,
    input  logic        res,
    input  logic        sh_cp,
    input  logic        st_cp,
    input  logic        ds,
    input  logic        mr_n,
    input  logic [7:0]  cat,
    output logic [63:0] red_frame,
    output logic [63:0] blue_frame,
    output logic        frame_valid,
    output logic        count_err,
    output logic        row_err
);

    localparam int unsigned IN_W    = 12;
    localparam logic [4:0]  CNT_MAX = 5'd31;

    logic [IN_W-1:0]     sync_q [SYNC_STAGES];
    logic [IN_W-1:0]     pins;
    logic [IN_W-1:0]     sync_s;
    logic                sh_s, st_s, ds_s, mr_n_s;
    logic [7:0]          cat_s;

    logic                sh_prev_q, st_prev_q;
    logic [ROW_BITS-1:0] sr_q, sr_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [63:0]         red_buf_q, blue_buf_q;
    logic [7:0]          mask_q;
    logic                pend_q;
    logic [63:0]         red_frame_q, blue_frame_q;
    logic                frame_valid_q, count_err_q, row_err_q;

    logic                sh_rise, st_rise, cat_onehot;
    logic [2:0]          row_idx;
    logic [7:0]          mask_new;
    logic [ROW_BITS-1:0] row_val;
    logic [4:0]          cnt_eff;

    assign pins   = {cat, mr_n, ds, st_cp, sh_cp};
    assign sync_s = sync_q[SYNC_STAGES-1];
    assign sh_s   = sync_s[0];
    assign st_s   = sync_s[1];
    assign ds_s   = sync_s[2];
    assign mr_n_s = sync_s[3];
    assign cat_s  = sync_s[11:4];

    assign sh_rise    = sh_s & ~sh_prev_q;
    assign st_rise    = st_s & ~st_prev_q;
    assign cat_onehot = (cat_s != '0) && ((cat_s & (cat_s - 8'd1)) == '0);
    assign mask_new   = mask_q | 8'(8'd1 << row_idx);

    // During a clear the register may still hold stale data for one cycle; the
    // latch must see the cleared value regardless.
    assign row_val = mr_n_s ? sr_q  : '0;
    assign cnt_eff = mr_n_s ? cnt_q : '0;

    always_comb begin
        row_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (cat_s[i]) row_idx = 3'(i);
        end
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (!mr_n_s) begin
            sr_d  = '0;
            cnt_d = '0;
        end else begin
            if (sh_rise) sr_d = {sr_q[ROW_BITS-2:0], ds_s};
            if (st_rise)
                cnt_d = sh_rise ? 5'd1 : 5'd0;
            else if (sh_rise && cnt_q != CNT_MAX)
                cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge CLK or negedge res) begin
        if (!res) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            sh_prev_q     <= 1'b0;
            st_prev_q     <= 1'b0;
            sr_q          <= '0;
            cnt_q         <= '0;
            red_buf_q     <= '0;
            blue_buf_q    <= '0;
            mask_q        <= '0;
            pend_q        <= 1'b0;
            red_frame_q   <= '0;
            blue_frame_q  <= '0;
            frame_valid_q <= 1'b0;
            count_err_q   <= 1'b0;
            row_err_q     <= 1'b0;
        end else begin
            sync_q[0] <= pins;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            sh_prev_q     <= sh_s;
            st_prev_q     <= st_s;
            sr_q          <= sr_d;
            cnt_q         <= cnt_d;
            pend_q        <= 1'b0;
            frame_valid_q <= pend_q;
            count_err_q   <= 1'b0;
            row_err_q     <= 1'b0;
            if (pend_q) begin
                red_frame_q  <= red_buf_q;
                blue_frame_q <= blue_buf_q;
            end
            if (st_rise) begin
                count_err_q <= (cnt_eff != 5'(ROW_BITS));
                if (cat_onehot) begin
                    red_buf_q[{row_idx, 3'b000} +: 8]  <= row_val[ROW_BITS-1 -: 8];
                    blue_buf_q[{row_idx, 3'b000} +: 8] <= row_val[7:0];
                    // Mask is cleared here; the frame copy follows next cycle once
                    // the buffer holds the completing row.
                    if (mask_new == 8'hFF) begin
                        mask_q <= '0;
                        pend_q <= 1'b1;
                    end else begin
                        mask_q <= mask_new;
                    end
                end else begin
                    row_err_q <= 1'b1;
                end
            end
        end
    end

    assign red_frame   = red_frame_q;
    assign blue_frame  = blue_frame_q;
    assign frame_valid = frame_valid_q;
    assign count_err   = count_err_q;
    assign row_err     = row_err_q;

endmodule

// File: tb/tb_dot_matrix_frame_capture.sv
// Bench for dot_matrix_frame_capture: table-driven frames plus hand-written
// corner sequences, with expected frames queued and checked on frame_valid.
module tb_dot_matrix_frame_capture;

    localparam int unsigned SS = 2;

    logic        CLK = 1'b0;
    logic        res = 1'b0;
    logic        sh_cp = 1'b0, st_cp = 1'b0, ds = 1'b0, mr_n = 1'b1;
    logic [7:0]  cat = '0;
    logic [63:0] red_frame, blue_frame;
    logic        frame_valid, count_err, row_err;

    dot_matrix_frame_capture #(.SYNC_STAGES(SS), .ROW_BITS(16)) dut (
        .CLK(CLK), .res(res), .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds), .mr_n(mr_n),
        .cat(cat), .red_frame(red_frame), .blue_frame(blue_frame),
        .frame_valid(frame_valid), .count_err(count_err), .row_err(row_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] red;
        logic [63:0] blue;
    } frame_t;

    typedef struct {
        string            name;
        logic [7:0][15:0] rows;
        bit               desc;
        logic [63:0]      exp_red;
        logic [63:0]      exp_blue;
    } vec_t;

    frame_t      sb_q[$];
    logic [63:0] m_red = '0, m_blue = '0;
    int          tests = 0, fails = 0;
    int unsigned cyc = 0, st_cyc = 0, last_fv_cyc = 0;
    int          fv_cnt = 0, cerr_cnt = 0, rerr_cnt = 0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin : mon
        frame_t f;
        if (res) begin
            if (count_err) cerr_cnt++;
            if (row_err) rerr_cnt++;
            if (frame_valid) begin
                fv_cnt++;
                last_fv_cyc = cyc;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame_valid: got 1 expected 0 (no frame pending)");
                end else begin
                    f = sb_q.pop_front();
                    check("red_frame", red_frame, f.red);
                    check("blue_frame", blue_frame, f.blue);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic shift_bits(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ds = w[i];
            tick(3);
            sh_cp = 1'b1;
            tick(3);
            sh_cp = 1'b0;
        end
    endtask

    task automatic latch(input logic [7:0] c);
        cat = c;
        tick(3);
        st_cp  = 1'b1;
        st_cyc = cyc;
        tick(3);
        st_cp = 1'b0;
        tick(3);
    endtask

    task automatic model_row(input int r, input logic [15:0] w);
        m_red[r*8 +: 8]  = w[15:8];
        m_blue[r*8 +: 8] = w[7:0];
    endtask

    task automatic push_model();
        frame_t f;
        f.red  = m_red;
        f.blue = m_blue;
        sb_q.push_back(f);
    endtask

    task automatic send_row(input int r, input logic [15:0] w, input bit push);
        shift_bits(w, 16);
        model_row(r, w);
        if (push) push_model();
        latch(8'(1 << r));
    endtask

    task automatic pulse_reset();
        res = 1'b0;
        tick(2);
        res = 1'b1;
        m_red  = '0;
        m_blue = '0;
        tick(3);
    endtask

    vec_t vecs[3];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fv0, ce0, re0;
        frame_t f;

        vecs[0].name = "uniform_A55A";
        vecs[0].rows = {8{16'hA55A}};
        vecs[0].desc = 1'b0;
        vecs[0].exp_red  = 64'hA5A5A5A5A5A5A5A5;
        vecs[0].exp_blue = 64'h5A5A5A5A5A5A5A5A;
        vecs[1].name = "rows_7_to_0";
        vecs[1].rows = {16'h0707, 16'h0606, 16'h0505, 16'h0404,
                        16'h0303, 16'h0202, 16'h0101, 16'h0000};
        vecs[1].desc = 1'b1;
        vecs[1].exp_red  = 64'h0706050403020100;
        vecs[1].exp_blue = 64'h0706050403020100;
        vecs[2].name = "walking_one";
        vecs[2].rows = {16'h807F, 16'h40BF, 16'h20DF, 16'h10EF,
                        16'h08F7, 16'h04FB, 16'h02FD, 16'h01FE};
        vecs[2].desc = 1'b0;
        vecs[2].exp_red  = 64'h8040201008040201;
        vecs[2].exp_blue = 64'h7FBFDFEFF7FBFDFE;

        tick(3);
        check("reset_red", red_frame, '0);
        check("reset_blue", blue_frame, '0);
        check("reset_fv", 64'(frame_valid), '0);
        check("reset_cerr", 64'(count_err), '0);
        check("reset_rerr", 64'(row_err), '0);
        res = 1'b1;
        tick(3);

        // Table-driven full frames
        fv0 = fv_cnt; ce0 = cerr_cnt; re0 = rerr_cnt;
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < 8; k++) begin
                int r;
                r = vecs[v].desc ? 7 - k : k;
                if (k == 7) begin
                    f.red  = vecs[v].exp_red;
                    f.blue = vecs[v].exp_blue;
                    sb_q.push_back(f);
                end
                send_row(r, vecs[v].rows[r], 1'b0);
            end
            check({vecs[v].name, "_fv_count"}, 64'(fv_cnt - fv0), 64'(v + 1));
            if (v == 1) check("fv_latency", 64'(last_fv_cyc - st_cyc), 64'(SS + 2));
        end
        check("table_cerr", 64'(cerr_cnt - ce0), '0);
        check("table_rerr", 64'(rerr_cnt - re0), '0);
        tick(20);
        check("hold_red", red_frame, vecs[2].exp_red);
        check("hold_blue", blue_frame, vecs[2].exp_blue);

        // Short row: 15 shifts
        pulse_reset();
        ce0 = cerr_cnt;
        shift_bits(16'h1234, 15);
        model_row(0, 16'h1234);
        latch(8'h01);
        check("short_row_cerr", 64'(cerr_cnt - ce0), 64'd1);
        for (int r = 1; r < 8; r++) send_row(r, 16'hFF00, r == 7);
        check("short_row_next_ok", 64'(cerr_cnt - ce0), 64'd1);

        // Bad row selects
        fv0 = fv_cnt; ce0 = cerr_cnt; re0 = rerr_cnt;
        latch(8'h03);
        latch(8'h00);
        check("bad_cat_rerr", 64'(rerr_cnt - re0), 64'd2);
        check("bad_cat_cerr", 64'(cerr_cnt - ce0), 64'd2);
        for (int r = 1; r < 8; r++) send_row(r, {8'(r), 8'(~r)}, 1'b0);
        check("bad_cat_no_fv", 64'(fv_cnt - fv0), '0);
        send_row(0, 16'hC3C3, 1'b1);
        check("bad_cat_fv_after_row0", 64'(fv_cnt - fv0), 64'd1);

        // Clear mid-row
        ce0 = cerr_cnt;
        shift_bits(16'h00FF, 8);
        mr_n = 1'b0;
        tick(3);
        shift_bits(16'h000F, 4);
        model_row(3, 16'h0000);
        latch(8'h08);
        mr_n = 1'b1;
        tick(3);
        check("clear_cerr", 64'(cerr_cnt - ce0), 64'd1);
        for (int r = 0; r < 8; r++) if (r != 3) send_row(r, 16'hABCD, r == 7);

        // Simultaneous shift and latch
        ce0 = cerr_cnt;
        shift_bits(16'h5AC3, 16);
        model_row(0, 16'h5AC3);
        ds  = 1'b1;
        cat = 8'h01;
        tick(3);
        sh_cp = 1'b1;
        st_cp = 1'b1;
        tick(3);
        sh_cp = 1'b0;
        st_cp = 1'b0;
        tick(3);
        shift_bits(16'h9F31, 15);
        model_row(1, 16'h9F31);
        latch(8'h02);
        check("simul_cerr", 64'(cerr_cnt - ce0), '0);
        for (int r = 2; r < 8; r++) send_row(r, 16'h0F0F, r == 7);

        // Reset mid-frame
        for (int r = 0; r < 4; r++) send_row(r, 16'h7777, 1'b0);
        res = 1'b0;
        #1;
        check("midreset_red", red_frame, '0);
        check("midreset_blue", blue_frame, '0);
        check("midreset_fv", 64'(frame_valid), '0);
        tick(2);
        res = 1'b1;
        m_red  = '0;
        m_blue = '0;
        tick(3);
        fv0 = fv_cnt; ce0 = cerr_cnt; re0 = rerr_cnt;
        for (int r = 4; r < 8; r++) send_row(r, 16'h1E1E, 1'b0);
        check("midreset_no_fv", 64'(fv_cnt - fv0), '0);
        for (int r = 0; r < 4; r++) send_row(r, 16'h2D2D, r == 3);
        check("midreset_fv_once", 64'(fv_cnt - fv0), 64'd1);
        check("midreset_no_err", 64'((cerr_cnt - ce0) + (rerr_cnt - re0)), '0);

        tick(10);
        check("scoreboard_drained", 64'(sb_q.size()), '0);
        check("total_frames", 64'(fv_cnt), 64'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
